// File: rtl/mw_controller_gen.sv
// -----------------------------------------------------------------------------
// mw_controller_gen
// Microwave oven controller: keypad BCD time entry, 1 s tick divider, mm:ss
// countdown, door/start/stop interlock FSM and a power-level duty generator.
//
// Optional feature macro: MWC_QUICK_START_EN
//   defined   : start in IDLE (door closed) loads 00:30 at level 10 and cooks;
//               start in COOK adds 30 s (BCD-correct, saturating).
//   undefined : start in IDLE and in COOK is ignored.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   start        start/resume request (level)
//   stop         pause request
//   clear        abort, zero time, restore default power
//   door_closed  door interlock, 1 = closed
//   key_valid    one-cycle keypad strobe
//   key_digit    BCD key value 0..9 (values above 9 are ignored)
//   key_power    with key_valid: digit selects power level (0 means 10)
//   mag_on       magnetron enable (registered enable gated by door_closed)
//   time_bcd     packed BCD time, digit 0 = seconds ones at the LSBs
//   state        IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
//   done         one-cycle pulse on entering DONE
//   beep         high while in DONE
// -----------------------------------------------------------------------------
module mw_controller_gen #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned POWER_WINDOW  = 10,
  parameter int unsigned DEFAULT_POWER = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  door_closed,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  key_power,
  output logic                  mag_on,
  output logic [4*DIGITS-1:0]   time_bcd,
  output logic [2:0]            state,
  output logic                  done,
  output logic                  beep
);

  localparam int unsigned TW  = 4 * DIGITS;
  localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW  = (POWER_WINDOW > 1) ? $clog2(POWER_WINDOW) : 1;
  localparam int unsigned PW  = $clog2(POWER_WINDOW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    time_q, time_d;
  logic [PW-1:0]    power_q, power_d;
  logic [TCW-1:0]   tick_q, tick_d;
  logic [WW-1:0]    win_q, win_d;
  logic             mag_q, mag_d;
  logic             done_q, done_d;
  logic             beep_q, beep_d;

  logic             tick;
  logic             key_ok;
  logic             resume_ok;
  logic [TW-1:0]    time_dec;
  logic [TW-1:0]    time_shift;
  logic [TW-1:0]    time_next;

  // BCD countdown by one second; seconds tens wraps to 5, value 0 stays 0.
  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic          borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    if (borrow) r = '0;
    return r;
  endfunction

  // Keypad level to duty level: 0 selects 10, result capped at the window.
  function automatic logic [PW-1:0] clamp_power(input logic [3:0] d);
    int unsigned lvl;
    lvl = (d == 4'd0) ? 32'd10 : 32'(d);
    if (lvl > POWER_WINDOW) lvl = POWER_WINDOW;
    return PW'(lvl);
  endfunction

`ifdef MWC_QUICK_START_EN
  // Add 30 s; seconds may hold 60..99 from entry so carry into minutes can be 2.
  function automatic logic [TW-1:0] bcd_add30(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    int unsigned   s;
    int unsigned   c;
    int unsigned   d;
    r        = t;
    s        = 32'd10 * 32'(t[7:4]) + 32'(t[3:0]) + 32'd30;
    c        = s / 32'd60;
    s        = s % 32'd60;
    r[3:0]   = 4'(s % 32'd10);
    r[7:4]   = 4'(s / 32'd10);
    for (int i = 2; i < DIGITS; i++) begin
      d = 32'(t[4*i +: 4]) + c;
      if (d > 32'd9) begin
        d = d - 32'd10;
        c = 32'd1;
      end else begin
        c = 32'd0;
      end
      r[4*i +: 4] = 4'(d);
    end
    // Minutes overflowed: pin to the largest displayable time.
    if (c != 32'd0) begin
      for (int i = 2; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
      r[7:0] = 8'h59;
    end
    return r;
  endfunction
`endif

  // 1 s tick fires on the last divider count while cooking.
  assign tick       = (state_q == S_COOK) && (tick_q == TCW'(TICK_DIV - 1));
  assign key_ok     = key_valid && (key_digit <= 4'd9);
  assign resume_ok  = start && door_closed && !stop;
  assign time_dec   = bcd_dec(time_q);
  assign time_shift = {time_q[TW-5:0], key_digit};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    power_d   = power_q;
    tick_d    = tick_q;
    win_d     = win_q;
    time_next = time_q;

    case (state_q)
      S_IDLE, S_SET: begin
        if (clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          power_d = PW'(DEFAULT_POWER);
        end else if ((state_q == S_SET) && resume_ok) begin
          state_d = S_COOK;
          tick_d  = '0;
          win_d   = '0;
`ifdef MWC_QUICK_START_EN
        end else if ((state_q == S_IDLE) && resume_ok) begin
          state_d = S_COOK;
          time_d  = TW'(8'h30);
          power_d = clamp_power(4'd10);
          tick_d  = '0;
          win_d   = '0;
`endif
        end else if (key_ok) begin
          if (key_power) begin
            power_d = clamp_power(key_digit);
          end else begin
            time_d = time_shift;
            if ((state_q == S_IDLE) && (time_shift != '0)) state_d = S_SET;
          end
        end
      end

      S_COOK: begin
        if (clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          power_d = PW'(DEFAULT_POWER);
        end else if (tick && (time_dec == '0)) begin
          // Reaching zero wins over a same-cycle stop or door open.
          state_d = S_DONE;
          time_d  = '0;
          tick_d  = '0;
        end else if (!door_closed || stop) begin
          state_d = S_PAUSE;
        end else begin
          if (tick) begin
            time_next = time_dec;
            tick_d    = '0;
            win_d     = (win_q == WW'(POWER_WINDOW - 1)) ? '0 : win_q + WW'(1);
          end else begin
            tick_d    = tick_q + TCW'(1);
          end
`ifdef MWC_QUICK_START_EN
          if (start) time_next = bcd_add30(time_next);
`endif
          time_d = time_next;
        end
      end

      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          power_d = PW'(DEFAULT_POWER);
        end else if (resume_ok) begin
          // Time is kept; divider and duty window restart.
          state_d = S_COOK;
          tick_d  = '0;
          win_d   = '0;
        end
      end

      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          power_d = PW'(DEFAULT_POWER);
        end else if (stop || !door_closed) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with it.
  always_comb begin
    mag_d  = 1'b0;
    done_d = 1'b0;
    beep_d = 1'b0;
    if (state_d == S_COOK) mag_d = (32'(win_d) < 32'(power_d));
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
    beep_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= '0;
      power_q <= PW'(DEFAULT_POWER);
      tick_q  <= '0;
      win_q   <= '0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      time_q  <= time_d;
      power_q <= power_d;
      tick_q  <= tick_d;
      win_q   <= win_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
      beep_q  <= beep_d;
    end
  end

  // Door opening must kill the magnetron without waiting for a clock.
  assign mag_on   = mag_q & door_closed;
  assign time_bcd = time_q;
  assign state    = state_q;
  assign done     = done_q;
  assign beep     = beep_q;

endmodule
